regfile_port_arbiter: RTL and testbench
=======================================

# regfile_port_arbiter

Parametrised, clocked arbiter that shares one register-file port (two combinational reads, one synchronous write) among NUM_CH decode/execute channels. It replaces opcode-steered muxing with a per-channel request/grant handshake, round-robin fairness, x0 protection and a registered read-return stage. It sits between the per-format instruction units and the register file.

## Interface
- NUM_CH, 6, number of requesting channels (2..16)
- XLEN, 32, register data width
- AW, 5, register address width
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous, active-low reset
- i_REQ  in  NUM_CH  per-channel access request, level, held until granted
- i_WE  in  NUM_CH  per-channel write enable, qualifies i_REG_IN
- i_RD  in  NUM_CH*AW  destination addresses, channel k at [k*AW +: AW]
- i_RS1  in  NUM_CH*AW  source-1 addresses
- i_RS2  in  NUM_CH*AW  source-2 addresses
- i_REG_IN  in  NUM_CH*XLEN  write data, channel k at [k*XLEN +: XLEN]
- o_GNT  out  NUM_CH  one-hot grant, combinational, same cycle as accepted request
- o_RVALID  out  NUM_CH  one-hot read-return strobe, registered
- o_REG_OUT1  out  XLEN  registered rs1 data, shared by all channels, qualified by o_RVALID
- o_REG_OUT2  out  XLEN  registered rs2 data, qualified by o_RVALID
- o_X_RD, o_X_RS1, o_X_RS2  out  AW  address lines to the register file
- o_X_WE  out  1  register-file write enable
- o_X_REG_IN  out  XLEN  register-file write data
- i_X_REG_OUT1, i_X_REG_OUT2  in  XLEN  combinational register-file read data

## Operation
- Arbitration: round-robin pointer PTR (clog2(NUM_CH) bits). Winner = first k with i_REQ[k]=1 searching PTR, PTR+1, … NUM_CH-1, 0, … (modulo NUM_CH). At most one o_GNT bit set; o_GNT=0 when i_REQ=0.
- On grant of channel k: o_X_RD/RS1/RS2 = channel k fields; o_X_REG_IN = channel k data; o_X_WE = i_WE[k] && (i_RD[k] != 0).
- No grant: all o_X_* driven 0, o_X_WE=0.
- x0 rule: write to address 0 is suppressed; read of address 0 returns 0 regardless of i_X_REG_OUT*.
- Read semantics: rs values are sampled before the same-cycle write lands (read-before-write); a channel reading and writing the same register gets the old value.
- Return stage: at the grant edge, register o_REG_OUT1/2 from i_X_REG_OUT1/2 (x0-masked) and set o_RVALID = o_GNT. Otherwise o_RVALID=0; o_REG_OUT1/2 hold their last value.
- PTR update: on a grant to k, PTR <= (k+1) mod NUM_CH; no grant, PTR holds.
- Write-only requests (addresses don't care) still produce an o_RVALID strobe; the channel ignores the data.

## Timing
- Reset (RST_N low, async): PTR=0, o_RVALID=0, o_REG_OUT1=0, o_REG_OUT2=0. Combinational outputs follow inputs, with PTR=0.
- Cycle t: request seen, o_GNT asserted, write committed at the end of t. Cycle t+1: o_RVALID[k]=1 with data. Read latency is 1 cycle; throughput is one access per cycle.
- Back-to-back: a write in cycle t is visible to a read granted in t+1. The register file provides this; the arbiter does no bypass.
- A channel deasserting i_REQ before grant is legal and drops the request silently.
- Reset mid-access: a pending return is lost (o_RVALID forced 0); the channel must re-request.
- Simultaneous equal requests are resolved purely by PTR; starvation bound is NUM_CH-1 grants.

## Test plan
- Reset: hold RST_N=0 with random inputs -> o_RVALID=0, o_REG_OUT1/2=0. First request from ch3 after release -> o_GNT=6'b001000, PTR becomes 4.
- Single channel: ch0 writes x5=0xDEADBEEF in cycle t, then reads rs1=x5 in t+1 -> o_RVALID[0]=1 at t+2 with o_REG_OUT1=0xDEADBEEF.
- x0: ch1 writes x0=0x1234 -> o_X_WE=0. Read rs2=x0 with model forcing i_X_REG_OUT2=0xFFFFFFFF -> o_REG_OUT2=0.
- Fairness: all 6 channels request continuously from PTR=0 -> grant order 0,1,2,3,4,5,0; each channel gets exactly one grant per 6 cycles.
- Read-before-write: ch2 with rd=rs1=x7 (x7=0x10) writes 0x20 -> return o_REG_OUT1=0x10; the next read of x7 returns 0x20.
- Async reset mid-access: assert RST_N low between a grant edge and the next edge -> o_RVALID drops immediately; PTR=0 after release.

Source files
------------

// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter: round-robin arbiter sharing one 2R1W register-file port among NUM_CH channels
// with x0 protection and a registered read-return stage.
module regfile_port_arbiter #(
    parameter int NUM_CH = 6,
    parameter int XLEN   = 32,
    parameter int AW     = 5
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic [NUM_CH-1:0]      i_REQ,
    input  logic [NUM_CH-1:0]      i_WE,
    input  logic [NUM_CH*AW-1:0]   i_RD,
    input  logic [NUM_CH*AW-1:0]   i_RS1,
    input  logic [NUM_CH*AW-1:0]   i_RS2,
    input  logic [NUM_CH*XLEN-1:0] i_REG_IN,
    output logic [NUM_CH-1:0]      o_GNT,
    output logic [NUM_CH-1:0]      o_RVALID,
    output logic [XLEN-1:0]        o_REG_OUT1,
    output logic [XLEN-1:0]        o_REG_OUT2,
    output logic [AW-1:0]          o_X_RD,
    output logic [AW-1:0]          o_X_RS1,
    output logic [AW-1:0]          o_X_RS2,
    output logic                   o_X_WE,
    output logic [XLEN-1:0]        o_X_REG_IN,
    input  logic [XLEN-1:0]        i_X_REG_OUT1,
    input  logic [XLEN-1:0]        i_X_REG_OUT2
);
    localparam int PW = $clog2(NUM_CH);

    logic [PW-1:0]     ptr_q, ptr_d, gidx;
    logic              gvld;
    logic [NUM_CH-1:0] rvalid_q;
    logic [XLEN-1:0]   out1_q, out2_q, out1_d, out2_d;

    // First requester at or after ptr_q, wrapping modulo NUM_CH
    always_comb begin : arb
        int idx;
        idx  = 0;
        gvld = 1'b0;
        gidx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!gvld && i_REQ[PW'(idx)]) begin
                gvld = 1'b1;
                gidx = PW'(idx);
            end
        end
    end

    always_comb begin
        o_GNT      = gvld ? (NUM_CH'(1) << gidx) : '0;
        o_X_RD     = gvld ? i_RD[gidx*AW +: AW] : '0;
        o_X_RS1    = gvld ? i_RS1[gidx*AW +: AW] : '0;
        o_X_RS2    = gvld ? i_RS2[gidx*AW +: AW] : '0;
        o_X_REG_IN = gvld ? i_REG_IN[gidx*XLEN +: XLEN] : '0;
        o_X_WE     = gvld && i_WE[gidx] && (o_X_RD != '0);
        out1_d     = (o_X_RS1 == '0) ? '0 : i_X_REG_OUT1;
        out2_d     = (o_X_RS2 == '0) ? '0 : i_X_REG_OUT2;
        ptr_d      = !gvld ? ptr_q : (gidx == PW'(NUM_CH - 1)) ? '0 : gidx + 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ptr_q    <= '0;
            rvalid_q <= '0;
            out1_q   <= '0;
            out2_q   <= '0;
        end else begin
            ptr_q    <= ptr_d;
            rvalid_q <= o_GNT;
            if (gvld) begin
                out1_q <= out1_d;
                out2_q <= out2_d;
            end
        end
    end

    assign o_RVALID   = rvalid_q;
    assign o_REG_OUT1 = out1_q;
    assign o_REG_OUT2 = out2_q;
endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb_regfile_port_arbiter: directed checks of arbitration, x0 rule, read-before-write and reset,
// with a simple register-file model on the shared port.
module tb_regfile_port_arbiter;
    localparam int N = 6;
    localparam int XLEN = 32;
    localparam int AW = 5;

    logic            CLK = 1'b0;
    logic            RST_N = 1'b0;
    logic [N-1:0]    i_REQ = '0, i_WE = '0;
    logic [N*AW-1:0] i_RD = '0, i_RS1 = '0, i_RS2 = '0;
    logic [N*XLEN-1:0] i_REG_IN = '0;
    logic [N-1:0]    o_GNT, o_RVALID;
    logic [XLEN-1:0] o_REG_OUT1, o_REG_OUT2, o_X_REG_IN, i_X_REG_OUT1, i_X_REG_OUT2;
    logic [AW-1:0]   o_X_RD, o_X_RS1, o_X_RS2;
    logic            o_X_WE;

    logic [XLEN-1:0] rf [32];
    logic            force_ff = 1'b0;
    int total = 0;
    int bad = 0;

    regfile_port_arbiter #(.NUM_CH(N), .XLEN(XLEN), .AW(AW)) dut (
        .CLK(CLK), .RST_N(RST_N), .i_REQ(i_REQ), .i_WE(i_WE), .i_RD(i_RD),
        .i_RS1(i_RS1), .i_RS2(i_RS2), .i_REG_IN(i_REG_IN), .o_GNT(o_GNT),
        .o_RVALID(o_RVALID), .o_REG_OUT1(o_REG_OUT1), .o_REG_OUT2(o_REG_OUT2),
        .o_X_RD(o_X_RD), .o_X_RS1(o_X_RS1), .o_X_RS2(o_X_RS2), .o_X_WE(o_X_WE),
        .o_X_REG_IN(o_X_REG_IN), .i_X_REG_OUT1(i_X_REG_OUT1), .i_X_REG_OUT2(i_X_REG_OUT2)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) if (o_X_WE) rf[o_X_RD] <= o_X_REG_IN;
    assign i_X_REG_OUT1 = force_ff ? '1 : rf[o_X_RS1];
    assign i_X_REG_OUT2 = force_ff ? '1 : rf[o_X_RS2];

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear();
        i_REQ = '0; i_WE = '0; i_RD = '0; i_RS1 = '0; i_RS2 = '0; i_REG_IN = '0;
    endtask

    task automatic set_ch(input int k, input logic we, input logic [AW-1:0] rd,
                          input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                          input logic [XLEN-1:0] d);
        i_REQ[k] = 1'b1;
        i_WE[k] = we;
        i_RD[k*AW +: AW] = rd;
        i_RS1[k*AW +: AW] = rs1;
        i_RS2[k*AW +: AW] = rs2;
        i_REG_IN[k*XLEN +: XLEN] = d;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 32; i++) rf[i] = '0;
        for (int c = 0; c < 4; c++) begin
            i_REQ = N'($urandom); i_WE = N'($urandom);
            i_RS1 = N*AW'({$urandom, $urandom}); i_RS2 = N*AW'({$urandom, $urandom});
            cycle();
        end
        total++; if (o_RVALID !== '0) begin bad++; $display("FAIL reset_rvalid got %h want 0", o_RVALID); end
        total++; if (o_REG_OUT1 !== '0) begin bad++; $display("FAIL reset_out1 got %h want 0", o_REG_OUT1); end
        total++; if (o_REG_OUT2 !== '0) begin bad++; $display("FAIL reset_out2 got %h want 0", o_REG_OUT2); end
        clear();
        for (int i = 0; i < 32; i++) rf[i] = '0;
        RST_N = 1'b1;
        set_ch(3, 1'b0, 5'd0, 5'd0, 5'd0, '0);
        #1;
        total++; if (o_GNT !== 6'b001000) begin bad++; $display("FAIL first_gnt got %b want 001000", o_GNT); end
        cycle();
        total++; if (o_RVALID !== 6'b001000) begin bad++; $display("FAIL first_rvalid got %b want 001000", o_RVALID); end
        i_REQ = '1;
        #1;
        total++; if (o_GNT !== 6'b010000) begin bad++; $display("FAIL ptr4_gnt got %b want 010000", o_GNT); end
        cycle();
        clear();
    endtask

    task automatic test_single();
        set_ch(0, 1'b1, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF);
        #1;
        total++; if (o_GNT !== 6'b000001) begin bad++; $display("FAIL single_gnt got %b want 000001", o_GNT); end
        total++; if (o_X_WE !== 1'b1 || o_X_RD !== 5'd5 || o_X_REG_IN !== 32'hDEADBEEF) begin
            bad++; $display("FAIL single_wport got we=%b rd=%0d d=%h want we=1 rd=5 d=deadbeef", o_X_WE, o_X_RD, o_X_REG_IN);
        end
        cycle();
        set_ch(0, 1'b0, 5'd0, 5'd5, 5'd0, '0);
        total++; if (o_RVALID !== 6'b000001) begin bad++; $display("FAIL wonly_rvalid got %b want 000001", o_RVALID); end
        cycle();
        clear();
        total++; if (o_RVALID !== 6'b000001 || o_REG_OUT1 !== 32'hDEADBEEF) begin
            bad++; $display("FAIL single_read got v=%b d=%h want v=000001 d=deadbeef", o_RVALID, o_REG_OUT1);
        end
        cycle();
        total++; if (o_RVALID !== '0 || o_REG_OUT1 !== 32'hDEADBEEF) begin
            bad++; $display("FAIL idle_hold got v=%b d=%h want v=0 d=deadbeef", o_RVALID, o_REG_OUT1);
        end
        total++; if (o_X_WE !== 1'b0 || o_X_RS1 !== '0 || o_X_REG_IN !== '0) begin
            bad++; $display("FAIL idle_port got we=%b rs1=%0d d=%h want 0", o_X_WE, o_X_RS1, o_X_REG_IN);
        end
    endtask

    task automatic test_x0();
        set_ch(1, 1'b1, 5'd0, 5'd0, 5'd0, 32'h1234);
        #1;
        total++; if (o_GNT !== 6'b000010 || o_X_WE !== 1'b0) begin
            bad++; $display("FAIL x0_write got gnt=%b we=%b want gnt=000010 we=0", o_GNT, o_X_WE);
        end
        cycle();
        set_ch(1, 1'b0, 5'd0, 5'd5, 5'd0, '0);
        force_ff = 1'b1;
        cycle();
        force_ff = 1'b0;
        clear();
        total++; if (o_REG_OUT2 !== '0) begin bad++; $display("FAIL x0_read got %h want 0", o_REG_OUT2); end
        total++; if (o_REG_OUT1 !== 32'hFFFFFFFF || o_RVALID !== 6'b000010) begin
            bad++; $display("FAIL x0_other got d=%h v=%b want d=ffffffff v=000010", o_REG_OUT1, o_RVALID);
        end
    endtask

    task automatic test_fairness();
        int cnt [N];
        logic [N-1:0] e, prev;
        for (int k = 0; k < N; k++) cnt[k] = 0;
        set_ch(5, 1'b0, 5'd0, 5'd0, 5'd0, '0);
        cycle();
        i_REQ = '1;
        prev = '0;
        for (int i = 0; i < 7; i++) begin
            #1;
            e = N'(1) << (i % N);
            total++; if (o_GNT !== e) begin bad++; $display("FAIL rr_gnt%0d got %b want %b", i, o_GNT, e); end
            if (i < N) for (int k = 0; k < N; k++) if (o_GNT[k]) cnt[k]++;
            cycle();
            total++; if (o_RVALID !== e) begin bad++; $display("FAIL rr_rvalid%0d got %b want %b", i, o_RVALID, e); end
            prev = e;
        end
        for (int k = 0; k < N; k++) begin
            total++; if (cnt[k] != 1) begin bad++; $display("FAIL rr_count ch%0d got %0d want 1", k, cnt[k]); end
        end
        clear();
        cycle();
    endtask

    task automatic test_rbw();
        set_ch(2, 1'b1, 5'd7, 5'd0, 5'd0, 32'h10);
        cycle();
        set_ch(2, 1'b1, 5'd7, 5'd7, 5'd0, 32'h20);
        cycle();
        total++; if (o_RVALID !== 6'b000100 || o_REG_OUT1 !== 32'h10) begin
            bad++; $display("FAIL rbw_old got v=%b d=%h want v=000100 d=10", o_RVALID, o_REG_OUT1);
        end
        set_ch(2, 1'b0, 5'd0, 5'd7, 5'd0, '0);
        cycle();
        clear();
        total++; if (o_REG_OUT1 !== 32'h20) begin bad++; $display("FAIL rbw_new got %h want 20", o_REG_OUT1); end
    endtask

    task automatic test_async_reset();
        set_ch(4, 1'b0, 5'd0, 5'd7, 5'd0, '0);
        cycle();
        total++; if (o_RVALID !== 6'b010000) begin bad++; $display("FAIL ar_pre got %b want 010000", o_RVALID); end
        #2 RST_N = 1'b0;
        #1;
        total++; if (o_RVALID !== '0 || o_REG_OUT1 !== '0) begin
            bad++; $display("FAIL ar_drop got v=%b d=%h want 0", o_RVALID, o_REG_OUT1);
        end
        cycle();
        RST_N = 1'b1;
        i_REQ = '1;
        #1;
        total++; if (o_GNT !== 6'b000001) begin bad++; $display("FAIL ar_ptr got %b want 000001", o_GNT); end
        cycle();
        clear();
        cycle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_x0();
        test_fairness();
        test_rbw();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
